// File: rtl/alu_regfile_pipe_if.sv
// Purpose : issue/result handshake bundle for alu_regfile_pipe.
// Latency : n/a (wires only).
// Backpr. : master drives in_valid/out_ready; slave drives in_ready/out_valid.
// Ports   : in_valid/in_ready, r1/r2/r3, aluctrl, immop, alusrc, regwrite (issue side);
//           out_valid/out_ready, aluout, zero (result side); a0 (reg[A0_INDEX] mirror).
interface alu_regfile_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int ALU_CTRL   = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADR_WIDTH-1:0]  r1;
    logic [ADR_WIDTH-1:0]  r2;
    logic [ADR_WIDTH-1:0]  r3;
    logic [ALU_CTRL-1:0]   aluctrl;
    logic [DATA_WIDTH-1:0] immop;
    logic                  alusrc;
    logic                  regwrite;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] aluout;
    logic                  zero;
    logic [DATA_WIDTH-1:0] a0;

    modport master (
        output in_valid, r1, r2, r3, aluctrl, immop, alusrc, regwrite, out_ready,
        input  in_ready, out_valid, aluout, zero, a0
    );

    modport slave (
        input  in_valid, r1, r2, r3, aluctrl, immop, alusrc, regwrite, out_ready,
        output in_ready, out_valid, aluout, zero, a0
    );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Purpose : two-stage ALU + register file (issue/execute -> writeback) with EX forwarding.
// Latency : issue in cycle N gives out_valid/aluout in N+1; regfile written at commit edge.
// Backpr. : in_ready = !out_valid || out_ready; EX entry holds stable while stalled.
// Ports   : clk, rst (async, active high); bus (slave modport of alu_regfile_pipe_if).
module alu_regfile_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int ALU_CTRL   = 3,
    parameter int A0_INDEX   = 10
) (
    input  logic              clk,
    input  logic              rst,
    alu_regfile_pipe_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADR_WIDTH;
    localparam int SH_W     = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // EX register
    logic                  r_ex_vld;
    logic [DATA_WIDTH-1:0] r_ex_dat;
    logic                  r_ex_zero;
    logic [ADR_WIDTH-1:0]  r_ex_rd;
    logic                  r_ex_we;

    logic                  w_issue;
    logic                  w_commit;
    logic                  w_fwd_ok;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_rs2;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [SH_W-1:0]       w_shamt;
    logic [DATA_WIDTH-1:0] w_alu;

    assign bus.in_ready  = !r_ex_vld || bus.out_ready;
    assign w_issue       = bus.in_valid && bus.in_ready;
    assign w_commit      = r_ex_vld && bus.out_ready;

    // The EX entry is the youngest producer, so it overrides the regfile even when
    // it is committing on this same edge (the regfile copy is not yet updated).
    assign w_fwd_ok = r_ex_vld && r_ex_we && (r_ex_rd != '0);

    always_comb begin
        w_op1 = '0;
        w_rs2 = '0;
        if (bus.r1 != '0)
            w_op1 = (w_fwd_ok && bus.r1 == r_ex_rd) ? r_ex_dat : r_regs[bus.r1];
        if (bus.r2 != '0)
            w_rs2 = (w_fwd_ok && bus.r2 == r_ex_rd) ? r_ex_dat : r_regs[bus.r2];
    end

    assign w_op2   = bus.alusrc ? bus.immop : w_rs2;
    // Only the low log2(width) bits form the shift amount.
    assign w_shamt = w_op2[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        case (bus.aluctrl)
            3'd0: w_alu = w_op1 + w_op2;
            3'd1: w_alu = w_op1 - w_op2;
            3'd2: w_alu = w_op1 & w_op2;
            3'd3: w_alu = w_op1 | w_op2;
            3'd4: w_alu = w_op1 ^ w_op2;
            3'd5: w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            3'd6: w_alu = w_op1 << w_shamt;
            3'd7: w_alu = w_op1 >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_vld  <= 1'b0;
            r_ex_dat  <= '0;
            r_ex_zero <= 1'b0;
            r_ex_rd   <= '0;
            r_ex_we   <= 1'b0;
        end else if (w_issue) begin
            r_ex_vld  <= 1'b1;
            r_ex_dat  <= w_alu;
            r_ex_zero <= (w_alu == '0);
            r_ex_rd   <= bus.r3;
            r_ex_we   <= bus.regwrite;
        end else if (w_commit) begin
            r_ex_vld  <= 1'b0;
        end
    end

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_commit && r_ex_we && (r_ex_rd != '0)) begin
            r_regs[r_ex_rd] <= r_ex_dat;
        end
    end

    assign bus.out_valid = r_ex_vld;
    assign bus.aluout    = r_ex_dat;
    assign bus.zero      = r_ex_zero;
    assign bus.a0        = r_regs[A0_INDEX];
endmodule

// File: tb/tb_alu_regfile_pipe.sv
module tb_alu_regfile_pipe;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, SRL = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_regfile_pipe_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .ALU_CTRL(3)) bus ();

    alu_regfile_pipe #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .ALU_CTRL(3), .A0_INDEX(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic [31:0] imm, input logic src,
                          input logic we);
        bus.in_valid = 1'b1;
        bus.aluctrl  = op;
        bus.r1       = a;
        bus.r2       = b;
        bus.r3       = d;
        bus.immop    = imm;
        bus.alusrc   = src;
        bus.regwrite = we;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [31:0] imm, input logic src,
                         input logic we);
        set_op(op, a, b, d, imm, src, we);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_op(ADD, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.in_valid  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference: an in-order interpreter. Issue updates the architectural view
    // immediately; committed state (what a0 shows) lags until the entry drains.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 8);
        if (r == 8) r = 10;
        return 5'(r);
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [12];
        ent_t        q [$];
        ent_t        e;
        logic [31:0] arch [32];
        logic [31:0] cmt  [32];
        logic [31:0] op1, op2, res;
        logic        exp_rdy;

        vecs[0]  = '{ADD,  32'd5,        32'd7,        32'd12};
        vecs[1]  = '{ADD,  32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[2]  = '{SUB,  32'd3,        32'd5,        32'hFFFFFFFE};
        vecs[3]  = '{AND_, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        vecs[4]  = '{OR_,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF};
        vecs[5]  = '{XOR_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        vecs[6]  = '{SLT,  32'hFFFFFFFF, 32'd1,        32'd1};
        vecs[7]  = '{SLT,  32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[8]  = '{SLL,  32'hFFFFFFFF, 32'h00000021, 32'hFFFFFFFE};
        vecs[9]  = '{SRL,  32'hFFFFFFFF, 32'd1,        32'h7FFFFFFF};
        vecs[10] = '{SRL,  32'h80000000, 32'h0000003F, 32'd1};
        vecs[11] = '{SLL,  32'd1,        32'h00000020, 32'd1};

        // Reset state
        do_reset();
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset aluout", bus.aluout, 32'd0);
        check("reset zero", bus.zero, 1'b0);
        check("reset a0", bus.a0, 32'd0);
        check("reset in_ready", bus.in_ready, 1'b1);

        // 1: single add, then read back from the regfile after commit
        issue(ADD, 0, 0, 5, 32'd7, 1'b1, 1'b1);
        check("t1 out_valid", bus.out_valid, 1'b1);
        check("t1 aluout", bus.aluout, 32'd7);
        check("t1 zero", bus.zero, 1'b0);
        step();
        check("t1 drained", bus.out_valid, 1'b0);
        issue(ADD, 5, 0, 7, 32'd0, 1'b0, 1'b1);
        check("t1 reg5", bus.aluout, 32'd7);

        // 2: back-to-back dependent issues through forwarding
        issue(ADD, 0, 0, 5, 32'd7, 1'b1, 1'b1);
        issue(ADD, 5, 5, 6, 32'd0, 1'b0, 1'b1);
        check("t2 fwd aluout", bus.aluout, 32'd14);
        step();
        issue(ADD, 6, 0, 7, 32'd0, 1'b0, 1'b1);
        check("t2 reg6", bus.aluout, 32'd14);
        step();

        // 3: backpressure with a pending issue that lands on the commit edge
        issue(ADD, 0, 0, 10, 32'h55, 1'b1, 1'b1);
        step();
        check("t3 a0 preload", bus.a0, 32'h55);
        bus.out_ready = 1'b0;
        issue(SUB, 0, 0, 10, 32'd0, 1'b1, 1'b1);
        check("t3 out_valid", bus.out_valid, 1'b1);
        check("t3 zero", bus.zero, 1'b1);
        check("t3 in_ready", bus.in_ready, 1'b0);
        set_op(ADD, 0, 0, 11, 32'd99, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t3 hold valid %0d", i), bus.out_valid, 1'b1);
            check($sformatf("t3 hold aluout %0d", i), bus.aluout, 32'd0);
            check($sformatf("t3 hold zero %0d", i), bus.zero, 1'b1);
            check($sformatf("t3 hold in_ready %0d", i), bus.in_ready, 1'b0);
            check($sformatf("t3 hold a0 %0d", i), bus.a0, 32'h55);
        end
        bus.out_ready = 1'b1;
        #1;
        check("t3 in_ready release", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("t3 same-edge aluout", bus.aluout, 32'd99);
        check("t3 same-edge a0", bus.a0, 32'd0);
        step();

        // 4: x0 is a sink and never forwards
        issue(ADD, 0, 0, 0, 32'd5, 1'b1, 1'b1);
        check("t4 x0 write aluout", bus.aluout, 32'd5);
        issue(ADD, 0, 0, 1, 32'd0, 1'b0, 1'b1);
        check("t4 x0 read aluout", bus.aluout, 32'd0);
        check("t4 x0 read zero", bus.zero, 1'b1);
        step();

        // 5: ALU table via a forwarded operand in x1
        for (int i = 0; i < 12; i++) begin
            issue(ADD, 0, 0, 1, vecs[i].a, 1'b1, 1'b1);
            issue(vecs[i].op, 1, 0, 2, vecs[i].b, 1'b1, 1'b1);
            check($sformatf("t5 vec%0d aluout", i), bus.aluout, vecs[i].exp);
            check($sformatf("t5 vec%0d zero", i), bus.zero, (vecs[i].exp == 32'd0));
        end
        step();

        // 6: reset while an entry is stalled
        issue(ADD, 0, 0, 10, 32'd9, 1'b1, 1'b1);
        step();
        check("t6 a0 nine", bus.a0, 32'd9);
        bus.out_ready = 1'b0;
        issue(ADD, 0, 0, 10, 32'd3, 1'b1, 1'b1);
        check("t6 stalled aluout", bus.aluout, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6 rst out_valid", bus.out_valid, 1'b0);
        check("t6 rst aluout", bus.aluout, 32'd0);
        check("t6 rst a0", bus.a0, 32'd0);
        check("t6 rst in_ready", bus.in_ready, 1'b1);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        issue(ADD, 10, 0, 12, 32'd0, 1'b0, 1'b1);
        check("t6 x10 after reset", bus.aluout, 32'd0);
        step();

        // Randomized run against the in-order reference
        do_reset();
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0;
            cmt[i]  = '0;
        end
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.r1        = pick_reg();
            bus.r2        = pick_reg();
            bus.r3        = pick_reg();
            bus.aluctrl   = 3'($urandom_range(0, 7));
            bus.immop     = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            bus.alusrc    = 1'($urandom_range(0, 1));
            bus.regwrite  = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || bus.out_ready;
            check("rand in_ready", bus.in_ready, exp_rdy);
            if (q.size() != 0 && bus.out_ready) begin
                e = q.pop_front();
                if (e.we && e.rd != 0) cmt[e.rd] = e.data;
            end
            if (bus.in_valid && exp_rdy) begin
                op1 = arch[bus.r1];
                op2 = bus.alusrc ? bus.immop : arch[bus.r2];
                res = ref_alu(bus.aluctrl, op1, op2);
                if (bus.regwrite && bus.r3 != 0) arch[bus.r3] = res;
                q.push_back('{res, bus.r3, bus.regwrite});
            end
            step();
            check("rand out_valid", bus.out_valid, (q.size() != 0));
            if (q.size() != 0) begin
                check("rand aluout", bus.aluout, q[0].data);
                check("rand zero", bus.zero, (q[0].data == 32'd0));
            end
            check("rand a0", bus.a0, cmt[10]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
